rr_uart_reporter: RTL and testbench

//  Consumer end of the alg_core result interface. Captures each RR-period strobe
//  (rr_period / rr_period_updated / r_peak_sample_num) into a small FIFO.

---
 rtl/rr_uart_reporter.sv | 148 ++++++++++++++
 tb/tb_rr_uart_reporter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_uart_reporter.sv
// rr_uart_reporter: queues RR-period records in a small FIFO and streams each one as a fixed 8N1 UART frame.
// Define RR_TIMESTAMP_EN to append the 24-bit R-peak sample index to every frame (header 0xA6, 6 bytes).
module rr_uart_reporter #(
  parameter int DATA_WIDTH   = 11,
  parameter int CTR_WIDTH    = 22,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_rr_period,
  input  logic                  i_rr_period_updated,
  input  logic [CTR_WIDTH-1:0]  i_r_peak_sample_num,
  input  logic                  i_ovf_clr,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_overflow
);

`ifdef RR_TIMESTAMP_EN
  localparam int         NBYTES  = 6;
  localparam int         ENTRY_W = 40;
  localparam logic [7:0] HEADER  = 8'hA6;
`else
  localparam int         NBYTES  = 3;
  localparam int         ENTRY_W = 16;
  localparam logic [7:0] HEADER  = 8'hA5;
`endif
  localparam int FRAME_W = NBYTES * 8;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int BYTE_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_reg, state_next;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
  logic [ENTRY_W-1:0] entry_in, entry_head;
  logic [FRAME_W-1:0] frame_reg;
  logic [7:0]         cur_byte;
  logic [CNT_W-1:0]   baud_cnt_reg;
  logic [2:0]         bit_idx_reg;
  logic [BYTE_W-1:0]  byte_idx_reg;
  logic               overflow_reg;
  logic               fifo_empty, fifo_full, push, pop, drop;
  logic               bit_done, last_bit, last_byte;
  logic [15:0]        rr16;

  assign rr16 = 16'(i_rr_period);
`ifdef RR_TIMESTAMP_EN
  logic [23:0] ts24;
  assign ts24     = 24'(i_r_peak_sample_num);
  assign entry_in = {rr16, ts24};
`else
  logic unused_ts;
  assign unused_ts = ^i_r_peak_sample_num;
  assign entry_in  = rr16;
`endif

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign pop        = i_ce && (state_reg == IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push       = i_ce && i_rr_period_updated && (!fifo_full || pop);
  assign drop       = i_ce && i_rr_period_updated && fifo_full && !pop;
  assign entry_head = mem[rd_ptr_reg[PTR_W-1:0]];

  assign bit_done  = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_idx_reg == 3'd7);
  assign last_byte = (byte_idx_reg == BYTE_W'(NBYTES - 1));
  assign cur_byte  = frame_reg[FRAME_W-1 -: 8];

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg[PTR_W-1:0]] <= entry_in;
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else if (i_ce) begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
      if (drop)           overflow_reg <= 1'b1;
      else if (i_ovf_clr) overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (i_ce) begin
      case (state_reg)
        IDLE:  if (!fifo_empty) state_next = START;
        START: if (bit_done) state_next = DATA;
        DATA:  if (bit_done && last_bit) state_next = STOP;
        STOP:  if (bit_done) state_next = last_byte ? IDLE : START;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    o_tx = 1'b1;
    case (state_reg)
      START:   o_tx = 1'b0;
      DATA:    o_tx = cur_byte[bit_idx_reg];
      default: o_tx = 1'b1;
    endcase
    o_busy     = !fifo_empty || (state_reg != IDLE);
    o_overflow = overflow_reg;
  end

  // Bit/byte sequencing; i_ce=0 freezes everything so the current bit is only stretched.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      frame_reg    <= '0;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
    end else if (i_ce) begin
      if (state_reg == IDLE || bit_done) baud_cnt_reg <= '0;
      else                               baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
      case (state_reg)
        IDLE: if (pop) begin
          frame_reg    <= {HEADER, entry_head};
          byte_idx_reg <= '0;
          bit_idx_reg  <= '0;
        end
        DATA: if (bit_done) bit_idx_reg <= bit_idx_reg + 3'd1;
        STOP: if (bit_done && !last_byte) begin
          byte_idx_reg <= byte_idx_reg + BYTE_W'(1);
          frame_reg    <= frame_reg << 8;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_uart_reporter.sv
// Directed bench for rr_uart_reporter at CLKS_PER_BIT=4: decodes the UART line and checks frames, timing, overflow, ce and reset.
module tb_rr_uart_reporter;
`ifdef RR_TIMESTAMP_EN
  localparam int NB = 6;
  localparam logic [7:0] HDR = 8'hA6;
`else
  localparam int NB = 3;
  localparam logic [7:0] HDR = 8'hA5;
`endif
  localparam int FRAME = NB * 40;

  logic        clk = 1'b0;
  logic        rst_n, ce, strobe, ovf_clr;
  logic [10:0] rr;
  logic [21:0] ts;
  logic        tx, busy, ovf;

  int errors = 0;
  int checks = 0;
  int n;
  logic       log_q[$];
  logic [8:0] rx_q[$];
  logic [7:0] exp_q[$];

  rr_uart_reporter #(
    .DATA_WIDTH(11), .CTR_WIDTH(22), .FIFO_DEPTH(8), .CLKS_PER_BIT(4)
  ) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_ce(ce), .i_rr_period(rr),
    .i_rr_period_updated(strobe), .i_r_peak_sample_num(ts), .i_ovf_clr(ovf_clr),
    .o_tx(tx), .o_busy(busy), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  // Line log of enabled cycles only, so a stalled bit decodes like a normal one.
  always @(posedge clk) begin
    #2;
    if (ce) log_q.push_back(tx);
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, output int cnt);
    cnt = 0;
    while (busy && cnt < budget) begin
      tick();
      cnt++;
    end
    if (busy) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic exp_frame(input logic [15:0] r, input logic [23:0] t);
    exp_q.push_back(HDR);
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
`ifdef RR_TIMESTAMP_EN
    exp_q.push_back(t[23:16]);
    exp_q.push_back(t[15:8]);
    exp_q.push_back(t[7:0]);
`else
    if (t != 24'd0) $display("note: timestamp ignored in this build");
`endif
  endtask

  task automatic decode();
    int i;
    logic [7:0] b;
    rx_q.delete();
    i = 0;
    while (i + 39 < log_q.size()) begin
      if (log_q[i] == 1'b0) begin
        for (int k = 0; k < 8; k++) b[k] = log_q[i + 6 + 4 * k];
        if (log_q[i + 2] !== 1'b0 || log_q[i + 38] !== 1'b1) rx_q.push_back(9'h100);
        else rx_q.push_back({1'b0, b});
        i += 40;
      end else begin
        i++;
      end
    end
  endtask

  task automatic cmp_frames(input string t);
    decode();
    chk({t, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < rx_q.size(); j++)
      chk($sformatf("%s_byte%0d", t, j), rx_q[j], {1'b0, exp_q[j]});
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; strobe = 1'b0; ovf_clr = 1'b0; rr = '0; ts = '0;
    #3;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: single frame, latency and exact frame length
    log_q.delete();
    rr = 11'h2F3; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk("t1_tx_n1", tx, 1'b1);
    chk("t1_busy_n1", busy, 1'b1);
    tick();
    chk("t1_tx_n2", tx, 1'b0);
    wait_idle(1000, n);
    chk("t1_busy_fall", n, FRAME);
    exp_frame(16'h02F3, 24'h0);
    cmp_frames("t1");

    // 2: ten back-to-back strobes, tenth dropped
    for (int i = 0; i < 10; i++) begin
      rr = 11'h100 + 11'(i); strobe = 1'b1;
      tick();
      if (i == 8) chk("t2_ovf_before", ovf, 1'b0);
    end
    strobe = 1'b0;
    chk("t2_ovf_set", ovf, 1'b1);
    wait_idle(5000, n);
    for (int i = 0; i < 9; i++) exp_frame(16'h0100 + 16'(i), 24'h0);
    cmp_frames("t2");
    chk("t2_ovf_sticky", ovf, 1'b1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t2_ovf_clr", ovf, 1'b0);

    // 3: ce low for 50 cycles inside data bit 0 of the header
    rr = 11'h155; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    repeat (6) tick();
    ce = 1'b0;
    for (int i = 0; i < 50; i++) begin
      strobe = (i < 10); rr = 11'h3FF;
      tick();
    end
    strobe = 1'b0; ce = 1'b1;
    wait_idle(1000, n);
    chk("t3_stretch", n, FRAME - 5);
    exp_frame(16'h0155, 24'h0);
    cmp_frames("t3");
    chk("t3_ovf", ovf, 1'b0);

    // 4: asynchronous reset in DATA of byte 1 with two records queued
    for (int i = 0; i < 3; i++) begin
      rr = 11'h0AA + 11'(i * 17); strobe = 1'b1;
      tick();
    end
    strobe = 1'b0;
    repeat (47) tick();
    chk("t4_tx_before", tx, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t4_tx_async", tx, 1'b1);
    chk("t4_busy_async", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    log_q.delete();
    repeat (200) tick();
    chk("t4_busy_after", busy, 1'b0);
    cmp_frames("t4");

`ifdef RR_TIMESTAMP_EN
    // 5: timestamp frame followed by a queued one after a single idle cycle
    rr = 11'h010; ts = 22'h3ABCDE; strobe = 1'b1;
    tick();
    rr = 11'h020; ts = 22'h000001;
    tick();
    strobe = 1'b0; ts = '0;
    chk("t5_tx_start", tx, 1'b0);
    repeat (FRAME) tick();
    chk("t5_gap", tx, 1'b1);
    tick();
    chk("t5_next_start", tx, 1'b0);
    wait_idle(2000, n);
    exp_frame(16'h0010, 24'h3ABCDE);
    exp_frame(16'h0020, 24'h000001);
    cmp_frames("t5");
`endif

    // 6: FIFO full, strobe lands in the IDLE cycle that pops
    for (int i = 0; i < 9; i++) begin
      rr = 11'h200 + 11'(i); strobe = 1'b1;
      tick();
    end
    strobe = 1'b0;
    repeat (FRAME - 7) tick();
    chk("t6_gap_tx", tx, 1'b1);
    chk("t6_gap_busy", busy, 1'b1);
    rr = 11'h2FF; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    chk("t6_no_gap", tx, 1'b0);
    chk("t6_ovf_now", ovf, 1'b0);
    wait_idle(5000, n);
    chk("t6_ovf_end", ovf, 1'b0);
    for (int i = 0; i < 9; i++) exp_frame(16'h0200 + 16'(i), 24'h0);
    exp_frame(16'h02FF, 24'h0);
    cmp_frames("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
